// File: rtl/fifo_byte_serializer.sv
// ----------------------------------------------------------------------------
// fifo_byte_serializer
//
// Drain stage for fifo_top. Whenever the FIFO reports stored data it pops one
// word, captures it, and streams it out as BYTE_W-bit bytes on a valid/ready
// handshake. The final byte of each word is tagged with last_o, and completed
// words are counted in word_cnt_o.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          asynchronous, active-high reset
//   fifo_pnding_i  FIFO holds at least one word
//   fifo_data_i    FIFO read data (valid RD_LATENCY cycles after the pop)
//   fifo_pop_o     one-cycle pop pulse per word
//   byte_o         current output byte
//   valid_o        byte_o is valid
//   ready_i        consumer accepts byte_o this cycle
//   last_o         byte_o is the final byte of its word (qualified by valid_o)
//   busy_o         FSM is not idle
//   word_cnt_o     fully transmitted words, wraps modulo 2^16
// ----------------------------------------------------------------------------
module fifo_byte_serializer #(
   parameter int BITS       = 32,
   parameter int BYTE_W     = 8,
   parameter int RD_LATENCY = 1,
   parameter int MSB_FIRST  = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              fifo_pnding_i,
   input  logic [BITS-1:0]   fifo_data_i,
   output logic              fifo_pop_o,
   output logic [BYTE_W-1:0] byte_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              last_o,
   output logic              busy_o,
   output logic [15:0]       word_cnt_o
);

   localparam int N     = BITS / BYTE_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_POP,
      S_WAIT,
      S_SEND
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [BITS-1:0]   word_q;
   logic [IDX_W-1:0]  idx_q;
   logic [15:0]       cnt_q;
   logic [BYTE_W-1:0] byte_sel;
   logic              accept;
   logic              last_accept;
   logic              capture;

   // Handshake decode. These feed state only, never an output port, so
   // ready_i has no combinational path to any output.
   assign accept      = (state_q == S_SEND) && ready_i;
   assign last_accept = accept && (idx_q == LAST_IDX);

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   // NOTE: every combinationally written signal gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (fifo_pnding_i) state_d = S_POP;
         end
         S_POP: begin
            // The FIFO may have been drained before the pop was granted;
            // in that case nothing was popped, so nothing is captured.
            if (!fifo_pnding_i)       state_d = S_IDLE;
            else if (RD_LATENCY == 0) state_d = S_SEND;
            else                      state_d = S_WAIT;
         end
         S_WAIT: begin
            state_d = S_SEND;
         end
         S_SEND: begin
            if (last_accept) state_d = fifo_pnding_i ? S_POP : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output decode (from registered state; the pop is additionally gated
   // by the FIFO's pending flag so an empty FIFO is never popped)
   // ---------------------------------------------------------------------
   always_comb begin
      fifo_pop_o = (state_q == S_POP) && fifo_pnding_i;
      valid_o    = (state_q == S_SEND);
      last_o     = (state_q == S_SEND) && (idx_q == LAST_IDX);
      busy_o     = (state_q != S_IDLE);
   end

   // Read data is sampled in POP when the FIFO is combinational, otherwise
   // one cycle later in WAIT, where the popped word is guaranteed present.
   always_comb begin
      capture = (state_q == S_WAIT) ||
                ((state_q == S_POP) && fifo_pnding_i && (RD_LATENCY == 0));
   end

   // ---------------------------------------------------------------------
   // Datapath: captured word, byte index, word counter
   // ---------------------------------------------------------------------
   // NOTE: the word register is reset along with the control state because
   // byte_o is read straight out of it and must be 0 during reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         word_q <= '0;
         idx_q  <= '0;
         cnt_q  <= '0;
      end else begin
         if (capture) begin
            word_q <= fifo_data_i;
            idx_q  <= '0;
         end else if (accept) begin
            idx_q <= last_accept ? '0 : idx_q + IDX_W'(1);
         end
         if (last_accept) cnt_q <= cnt_q + 16'd1;
      end
   end

   // Byte select: the word stays frozen during SEND, only the index moves,
   // so a stalled byte is held stable for free.
   always_comb begin
      byte_sel = '0;
      for (int k = 0; k < N; k++) begin
         if (idx_q == IDX_W'(k)) begin
            if (MSB_FIRST != 0) byte_sel = word_q[BITS-1-k*BYTE_W -: BYTE_W];
            else                byte_sel = word_q[k*BYTE_W +: BYTE_W];
         end
      end
   end

   assign byte_o     = byte_sel;
   assign word_cnt_o = cnt_q;

endmodule

// File: doc/fifo_byte_serializer.md
# fifo_byte_serializer

Downstream drain stage for `fifo_top`. Pops `BITS`-wide words from the FIFO whenever `pnding_o` indicates stored data, captures each word, and emits it as a stream of `BYTE_W`-bit bytes on a valid/ready interface. It tags the final byte of each word and counts completed words. It sits between the FIFO's read side (`pop_i`/`data_o`/`pnding_o`) and any byte-wide consumer (UART TX, SPI shifter, etc.).

## Interface
- `BITS`, 32, FIFO word width; must be an integer multiple of `BYTE_W`.
- `BYTE_W`, 8, output byte width.
- `RD_LATENCY`, 1, cycles from `fifo_pop_o` high to valid word on `fifo_data_i`; legal values 0 or 1.
- `MSB_FIRST`, 1, 1 = byte `[BITS-1 -: BYTE_W]` sent first; 0 = byte `[BYTE_W-1:0]` first.
- `clk_i`  in  1  single clock, all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `fifo_pnding_i`  in  1  FIFO holds at least one word (from `pnding_o`).
- `fifo_data_i`  in  BITS  FIFO read data (from `data_o`).
- `fifo_pop_o`  out  1  pop request (to `pop_i`), one-cycle pulse per word.
- `byte_o`  out  BYTE_W  current output byte.
- `valid_o`  out  1  `byte_o` is valid.
- `ready_i`  in  1  consumer accepts `byte_o` this cycle.
- `last_o`  out  1  `byte_o` is the final byte of its word; qualified by `valid_o`.
- `busy_o`  out  1  FSM not in IDLE.
- `word_cnt_o`  out  16  count of fully transmitted words, wraps modulo 2^16.

## Operation
- N = BITS/BYTE_W bytes per word. Internal byte index counts 0..N-1.
- FSM states: IDLE, POP, WAIT, SEND.
  - IDLE: if `fifo_pnding_i`=1 -> POP.
  - POP: `fifo_pop_o` = `fifo_pnding_i` (gated). If `fifo_pnding_i`=0 -> IDLE, no capture. Else if RD_LATENCY=0: capture `fifo_data_i` into the shift register -> SEND. Else -> WAIT.
  - WAIT (RD_LATENCY=1 only): capture `fifo_data_i` unconditionally -> SEND.
  - SEND: `valid_o`=1. On `valid_o & ready_i`, advance to the next byte. On acceptance of byte N-1: increment `word_cnt_o`; go to POP if `fifo_pnding_i`=1, else IDLE.
- `byte_o` selects from the captured word by index and `MSB_FIRST`. The captured word must not change during SEND.
- `last_o` = SEND and index = N-1.
- `busy_o` = state != IDLE.
- Exactly one pop per captured word. A pop is never issued while a word is held in SEND.

## Timing
- Reset values: `fifo_pop_o`=0, `valid_o`=0, `last_o`=0, `byte_o`=0, `busy_o`=0, `word_cnt_o`=0, state IDLE, index 0, shift register 0.
- `fifo_pop_o` and `valid_o` are decoded from registered state only. No combinational path from `ready_i` to any output.
- RD_LATENCY=1, FIFO nonempty at cycle 0 in IDLE:
  - cycle 1: POP, pop pulse.
  - cycle 2: WAIT, capture.
  - cycle 3: first byte valid.
  - With `ready_i` held at 1, bytes occupy cycles 3..3+N-1, so a word takes N+2 cycles.
  - Back-to-back words: the next pop occurs the cycle after the last byte is accepted.
- RD_LATENCY=0: first byte valid in cycle 2; a word takes N+1 cycles.
- Backpressure: while `valid_o`=1 and `ready_i`=0, `byte_o`, `last_o`, and `valid_o` hold stable. There is no limit on the stall length.
- Reset asserted mid-word:
  - all outputs return to reset values asynchronously.
  - the partially sent word is discarded, not re-popped.
  - `word_cnt_o` is cleared.
- `word_cnt_o` increments on the same edge that accepts the last byte and is visible the next cycle. 0xFFFF wraps to 0x0000.

## Test plan
- FIFO with one word 0x0000000A, BITS=32, MSB_FIRST=1, RD_LATENCY=1, `ready_i`=1 -> exactly one `fifo_pop_o` pulse. Bytes 0x00, 0x00, 0x00, 0x0A on 4 consecutive cycles. `last_o` only with 0x0A. `word_cnt_o`=1. Returns to IDLE with `busy_o`=0.
- FIFO filled to DEPTH=4 with 0x0A..0x0D, `ready_i`=1 -> 4 pops, 16 bytes in order (00,00,00,0A ... 00,00,00,0D). `word_cnt_o`=4. `fifo_pnding_i` ends at 0 and no fifth pop is issued.
- Word 0x11223344 with `ready_i` toggling 1,0,0,1,... -> each byte held stable through stalls. Sequence 11,22,33,44 delivered exactly once each.
- MSB_FIRST=0, RD_LATENCY=0, word 0xA1B2C3D4 -> pop then first byte valid the next cycle. Byte sequence D4, C3, B2, A1.
- Assert `rst_i` after 2 of 4 bytes of 0xDEADBEEF, FIFO also holding 0x0000000B -> outputs at reset values immediately. After release, next word sent is 0x0000000B (00,00,00,0B). `word_cnt_o`=1.
- `fifo_pnding_i`=0 for 20 cycles, then `fifo_pnding_i` dropping while in POP -> no `fifo_pop_o` ever asserted, `valid_o`=0, FSM back in IDLE.
